mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-003 SHALL: opcode  input  7  instruction bits [6:0] from instruction register output.
REQ-004 SHALL: branch_taken  input  1  ALU branch-compare result, valid in BRANCH state.
REQ-005 SHALL: mem_ready  input  1  memory access complete (used only with MEM_HANDSHAKE_EN).
REQ-006 SHALL: load_ir  output  1  load instruction register.
REQ-007 SHALL: pc_write  output  1  PC update enable; pc_src  output  2  0=PC+4, 1=branch/JAL target, 2=JALR target.
REQ-008 SHALL: mem_read, mem_write, iord  output  1 each  memory strobes; iord 0=PC address, 1=ALU address.
REQ-009 SHALL: reg_write  output  1; wb_sel  output  2  0=ALU, 1=memory data, 2=PC+4, 3=immediate.
REQ-010 SHALL: alu_src_a  output  1 (0=rs1, 1=PC); alu_src_b  output  2 (0=rs2, 1=imm, 2=const 4); alu_op  output  2 (0=add, 1=branch compare, 2=funct-decoded).
REQ-011 SHALL: illegal  output  1  sticky unsupported-opcode flag; state  output  4  current state code, debug.

Function
REQ-012 SHALL: Moore FSM, 4-bit state register; all outputs decode from current state only.
REQ-013 SHALL: states/codes FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, JALR=11, WB_IMM=12, AUIPC=13, TRAP=15.
REQ-014 SHALL: FETCH: mem_read=1, iord=0, load_ir=1, pc_write=1, pc_src=0 -> DECODE.
REQ-015 SHALL: DECODE dispatch on opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->ADDR, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->WB_IMM, 0010111->AUIPC, other->TRAP.
REQ-016 SHALL: EXEC_R (src_a=0, src_b=0, op=2) and EXEC_I (src_a=0, src_b=1, op=2) -> WB_ALU; AUIPC (src_a=1, src_b=1, op=0) -> WB_ALU.
REQ-017 SHALL: ADDR (src_a=0, src_b=1, op=0) -> MEM_RD if opcode=0000011, else MEM_WR.
REQ-018 SHALL: MEM_RD: mem_read=1, iord=1 -> WB_MEM; MEM_WR: mem_write=1, iord=1 -> FETCH.
REQ-019 SHALL: WB_ALU (wb_sel=0), WB_MEM (wb_sel=1), WB_IMM (wb_sel=3): reg_write=1 -> FETCH.
REQ-020 SHALL: BRANCH: alu_op=1, src_a=0, src_b=0, pc_src=1, pc_write=branch_taken -> FETCH.
REQ-021 SHALL: JAL (pc_src=1) and JALR (pc_src=2): pc_write=1, reg_write=1, wb_sel=2 -> FETCH.
REQ-022 SHALL: cycle counts from FETCH entry to next FETCH: R/I/AUIPC 4, load 5, store 4, branch 3, JAL/JALR 3, LUI 3.
REQ-023 SHALL: TRAP: illegal=1, all strobes 0, remain in TRAP until reset.
REQ-024 SHALL: all unused outputs 0 in every state; unreachable codes 14 -> TRAP.

Reset
REQ-025 SHALL: rst=0 at rising clk forces state=FETCH and clears illegal, overriding any transition or wait.
REQ-026 SHALL: while rst=0 all strobes (load_ir, pc_write, mem_read, mem_write, reg_write) be 0; outputs revert to FETCH decode on the first edge with rst=1.
REQ-027 SHALL: reset mid-operation (e.g. in MEM_WR or MEM_RD wait) abandon the instruction with no further strobes.

Configuration
REQ-028 SHALL: macro MEM_HANDSHAKE_EN defined: FETCH, MEM_RD, MEM_WR hold their state and strobes (load_ir, pc_write also held low until mem_ready=1 in FETCH) until mem_ready=1, then transition; REQ-022 counts grow by wait cycles.
REQ-029 SHALL: MEM_HANDSHAKE_EN undefined: mem_ready ignored, every memory state lasts exactly one cycle.

Verification
REQ-030 SHALL: reset then opcode=0110011 -> states 0,1,2,7,0; reg_write=1 only in state 7, wb_sel=0.
REQ-031 SHALL: opcode=0000011 -> states 0,1,4,5,8,0; mem_read=1, iord=1 in 5; reg_write=1, wb_sel=1 in 8.
REQ-032 SHALL: opcode=1100011, branch_taken=0 then 1 -> pc_write=0 then 1 in state 9, pc_src=1.
REQ-033 SHALL: opcode=1111111 -> state 15, illegal=1 held 10 cycles; rst=0 one cycle -> state 0, illegal=0.
REQ-034 SHALL: with MEM_HANDSHAKE_EN, store with mem_ready=0 for 3 cycles -> MEM_WR held 4 cycles, mem_write=1 throughout; rst=0 during wait -> FETCH next edge.

Source files
------------

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle RV32I-style control unit (Moore FSM)
//
// Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK for a multi-cycle
// datapath. The datapath controls are decoded from the current state only.
// Three exceptions are qualified by inputs:
//   - branch_taken qualifies pc_write in BRANCH.
//   - rst masks the strobes while reset is asserted.
//   - mem_ready gates load_ir / pc_write in FETCH, but only in the handshake
//     build.
//
// Optional feature macro: MEM_HANDSHAKE_EN
//   defined   : FETCH, MEM_RD and MEM_WR wait for mem_ready=1 before leaving
//   undefined : mem_ready is ignored, every memory state lasts one cycle
//
// Ports
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous active-low reset
//   opcode[6:0]  in   instruction register opcode field
//   branch_taken in   ALU branch-compare result (valid in BRANCH)
//   mem_ready    in   memory access complete (handshake build only)
//   load_ir      out  load instruction register
//   pc_write     out  PC update enable
//   pc_src[1:0]  out  0=PC+4, 1=branch/JAL target, 2=JALR target
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   iord         out  memory address select, 0=PC, 1=ALU
//   reg_write    out  register file write enable
//   wb_sel[1:0]  out  0=ALU, 1=memory data, 2=PC+4, 3=immediate
//   alu_src_a    out  0=rs1, 1=PC
//   alu_src_b    out  0=rs2, 1=imm, 2=const 4
//   alu_op[1:0]  out  0=add, 1=branch compare, 2=funct-decoded
//   illegal      out  sticky unsupported-opcode flag
//   state[3:0]   out  current state code (debug)
// ---------------------------------------------------------------------------
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       load_ir,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;

    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_WB_IMM = 4'd12,
        S_AUIPC  = 4'd13,
        S_TRAP   = 4'd15
    } state_t;

    // Per-state control word. pc_write is split by source so the FETCH part
    // can be gated by mem_ready and the BRANCH part by branch_taken.
    typedef struct packed {
        logic       load_ir;
        logic       pc_wr_fetch;
        logic       pc_wr_jump;
        logic       branch;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Moore decode: control word for a given state, everything else zero.
    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t d;
        d = '0;
        case (s)
            S_FETCH: begin
                d.mem_read    = 1'b1;
                d.load_ir     = 1'b1;
                d.pc_wr_fetch = 1'b1;
            end
            S_EXEC_R: begin
                d.alu_op = 2'd2;
            end
            S_EXEC_I: begin
                d.alu_src_b = 2'd1;
                d.alu_op    = 2'd2;
            end
            S_AUIPC: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'd1;
            end
            S_ADDR: begin
                d.alu_src_b = 2'd1;
            end
            S_MEM_RD: begin
                d.mem_read = 1'b1;
                d.iord     = 1'b1;
            end
            S_MEM_WR: begin
                d.mem_write = 1'b1;
                d.iord      = 1'b1;
            end
            S_WB_ALU: begin
                d.reg_write = 1'b1;
            end
            S_WB_MEM: begin
                d.reg_write = 1'b1;
                d.wb_sel    = 2'd1;
            end
            S_WB_IMM: begin
                d.reg_write = 1'b1;
                d.wb_sel    = 2'd3;
            end
            S_BRANCH: begin
                d.alu_op = 2'd1;
                d.pc_src = 2'd1;
                d.branch = 1'b1;
            end
            S_JAL: begin
                d.pc_src     = 2'd1;
                d.pc_wr_jump = 1'b1;
                d.reg_write  = 1'b1;
                d.wb_sel     = 2'd2;
            end
            S_JALR: begin
                d.pc_src     = 2'd2;
                d.pc_wr_jump = 1'b1;
                d.reg_write  = 1'b1;
                d.wb_sel     = 2'd2;
            end
            S_TRAP: begin
                d.illegal = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_mem_ok;

    // Memory-completion qualifier for FETCH / MEM_RD / MEM_WR.
`ifdef MEM_HANDSHAKE_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_ok           = 1'b1;
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = w_mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:           w_next = S_EXEC_R;
                    OP_ITYPE:           w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  w_next = S_ADDR;
                    OP_BRANCH:          w_next = S_BRANCH;
                    OP_JAL:             w_next = S_JAL;
                    OP_JALR:            w_next = S_JALR;
                    OP_LUI:             w_next = S_WB_IMM;
                    OP_AUIPC:           w_next = S_AUIPC;
                    default:            w_next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_AUIPC: w_next = S_WB_ALU;
            S_ADDR:   w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: w_next = w_mem_ok ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: w_next = w_mem_ok ? S_FETCH : S_MEM_WR;
            S_WB_ALU, S_WB_MEM, S_WB_IMM,
            S_BRANCH, S_JAL, S_JALR:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    // State and control-word registers. The control word is decoded from the
    // next state, so it always matches the current state without a decode
    // path after the flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_ctrl  <= f_decode(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next);
        end
    end

    // Strobes are masked while rst is low, so an abandoned instruction
    // issues nothing further.
    assign load_ir   = rst & r_ctrl.load_ir & w_mem_ok;
    assign pc_write  = rst & ((r_ctrl.pc_wr_fetch & w_mem_ok)
                            | r_ctrl.pc_wr_jump
                            | (r_ctrl.branch & branch_taken));
    assign mem_read  = rst & r_ctrl.mem_read;
    assign mem_write = rst & r_ctrl.mem_write;
    assign reg_write = rst & r_ctrl.reg_write;

    assign pc_src    = r_ctrl.pc_src;
    assign iord      = r_ctrl.iord;
    assign wb_sel    = r_ctrl.wb_sel;
    assign alu_src_a = r_ctrl.alu_src_a;
    assign alu_src_b = r_ctrl.alu_src_b;
    assign alu_op    = r_ctrl.alu_op;
    assign illegal   = r_ctrl.illegal;
    assign state     = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- table-driven bench for mc_ctrl. Each table row is one clock
// cycle. A row holds the inputs for that cycle and the expected state and
// control outputs. Hand-written sequences cover reset and the memory waits.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       load_ir, pc_write, mem_read, mem_write, iord, reg_write;
    logic       alu_src_a, illegal;
    logic [1:0] pc_src, wb_sel, alu_src_b, alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .load_ir      (load_ir),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .iord         (iord),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .state        (state)
    );

`ifdef MEM_HANDSHAKE_EN
    localparam logic MR = 1'b1;
`else
    localparam logic MR = 1'b0;   // mem_ready must be ignored in this build
`endif

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JL  = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Observed control vector:
    // {load_ir,pc_write,pc_src,mem_read,mem_write,iord,reg_write,wb_sel,
    //  alu_src_a,alu_src_b,alu_op,illegal}
    logic [15:0] obs;
    logic [4:0]  strobes;
    assign obs = {load_ir, pc_write, pc_src, mem_read, mem_write, iord,
                  reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, illegal};
    assign strobes = {load_ir, pc_write, mem_read, mem_write, reg_write};

    function automatic logic [15:0] mk(
        input logic lir, input logic pcw, input logic [1:0] psrc,
        input logic mrd, input logic mwr, input logic io, input logic rw,
        input logic [1:0] wb, input logic sa, input logic [1:0] sb,
        input logic [1:0] op, input logic ill);
        return {lir, pcw, psrc, mrd, mwr, io, rw, wb, sa, sb, op, ill};
    endfunction

    typedef struct {
        logic [6:0]  opc;
        logic        bt;
        logic [3:0]  st;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] E_FETCH, E_DEC, E_EXR, E_EXI, E_AUI, E_ADDR, E_MRD, E_MWR;
    logic [15:0] E_WBA, E_WBM, E_WBI, E_BR0, E_BR1, E_JAL, E_JALR, E_TRAP;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    task automatic add(input logic [6:0] opc, input logic bt,
                       input logic [3:0] st, input logic [15:0] exp);
        vec_t v;
        v.opc = opc;
        v.bt  = bt;
        v.st  = st;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //            lir pcw psrc mrd mwr io  rw  wb  sa  sb  op  ill
        E_FETCH = mk(1, 1, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
        E_DEC   = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
        E_EXR   = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd2, 0);
        E_EXI   = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd2, 0);
        E_AUI   = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0);
        E_ADDR  = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0);
        E_MRD   = mk(0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0);
        E_MWR   = mk(0, 0, 2'd0, 0, 1, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0);
        E_WBA   = mk(0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0, 0);
        E_WBM   = mk(0, 0, 2'd0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0);
        E_WBI   = mk(0, 0, 2'd0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 2'd0, 0);
        E_BR0   = mk(0, 0, 2'd1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 0);
        E_BR1   = mk(0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 0);
        E_JAL   = mk(0, 1, 2'd1, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0);
        E_JALR  = mk(0, 1, 2'd2, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0);
        E_TRAP  = mk(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1);

        // R-type: 0,1,2,7
        add(OP_R, 0, 4'd0, E_FETCH);  add(OP_R, 0, 4'd1, E_DEC);
        add(OP_R, 0, 4'd2, E_EXR);    add(OP_R, 0, 4'd7, E_WBA);
        // I-type: 0,1,3,7
        add(OP_I, 0, 4'd0, E_FETCH);  add(OP_I, 0, 4'd1, E_DEC);
        add(OP_I, 0, 4'd3, E_EXI);    add(OP_I, 0, 4'd7, E_WBA);
        // load: 0,1,4,5,8
        add(OP_LD, 0, 4'd0, E_FETCH); add(OP_LD, 0, 4'd1, E_DEC);
        add(OP_LD, 0, 4'd4, E_ADDR);  add(OP_LD, 0, 4'd5, E_MRD);
        add(OP_LD, 0, 4'd8, E_WBM);
        // store: 0,1,4,6
        add(OP_ST, 0, 4'd0, E_FETCH); add(OP_ST, 0, 4'd1, E_DEC);
        add(OP_ST, 0, 4'd4, E_ADDR);  add(OP_ST, 0, 4'd6, E_MWR);
        // branch not taken, then taken
        add(OP_BR, 0, 4'd0, E_FETCH); add(OP_BR, 0, 4'd1, E_DEC);
        add(OP_BR, 0, 4'd9, E_BR0);
        add(OP_BR, 1, 4'd0, E_FETCH); add(OP_BR, 1, 4'd1, E_DEC);
        add(OP_BR, 1, 4'd9, E_BR1);
        // JAL, JALR, LUI
        add(OP_JL, 0, 4'd0, E_FETCH); add(OP_JL, 0, 4'd1, E_DEC);
        add(OP_JL, 0, 4'd10, E_JAL);
        add(OP_JR, 0, 4'd0, E_FETCH); add(OP_JR, 0, 4'd1, E_DEC);
        add(OP_JR, 0, 4'd11, E_JALR);
        add(OP_LUI, 0, 4'd0, E_FETCH); add(OP_LUI, 0, 4'd1, E_DEC);
        add(OP_LUI, 0, 4'd12, E_WBI);
        // AUIPC: 0,1,13,7
        add(OP_AUI, 0, 4'd0, E_FETCH); add(OP_AUI, 0, 4'd1, E_DEC);
        add(OP_AUI, 0, 4'd13, E_AUI);  add(OP_AUI, 0, 4'd7, E_WBA);
        // illegal opcode: trap, held for 11 cycles
        add(OP_BAD, 0, 4'd0, E_FETCH); add(OP_BAD, 0, 4'd1, E_DEC);
        for (int k = 0; k < 11; k++) add(OP_BAD, 0, 4'd15, E_TRAP);

        // Reset
        rst          = 1'b0;
        opcode       = OP_R;
        branch_taken = 1'b0;
        mem_ready    = MR;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'(strobes), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // Table: reset is released in the first row's cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = 1'b1;
            opcode       = vecs[i].opc;
            branch_taken = vecs[i].bt;
            mem_ready    = MR;
            #1;
            chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("row%0d_ctrl", i), 32'(obs), 32'(vecs[i].exp));
        end

        // One reset cycle leaves TRAP and clears illegal
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("trap_rst_strobes", 32'(strobes), 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        opcode = OP_LD;
        #1;
        chk("trap_exit_state", 32'(state), 32'd0);
        chk("trap_exit_illegal", 32'(illegal), 32'd0);
        chk("trap_exit_ctrl", 32'(obs), 32'(E_FETCH));

        // Reset in the middle of a load abandons it
        tick();
        chk("ld_decode", 32'(state), 32'd1);
        tick();
        chk("ld_addr", 32'(state), 32'd4);
        tick();
        chk("ld_memrd", 32'(state), 32'd5);
        rst = 1'b0;
        #1;
        chk("ld_rst_strobes", 32'(strobes), 32'd0);
        tick();
        chk("ld_rst_state", 32'(state), 32'd0);
        chk("ld_rst_strobes2", 32'(strobes), 32'd0);
        rst    = 1'b1;
        opcode = OP_ST;
        #1;
        chk("post_rst_ctrl", 32'(obs), 32'(E_FETCH));

`ifdef MEM_HANDSHAKE_EN
        // FETCH waits for mem_ready with load_ir/pc_write low, mem_read high
        mem_ready = 1'b0;
        #1;
        chk("hs_fetch_wait_strb", 32'(strobes), 32'b00100);
        tick();
        chk("hs_fetch_hold", 32'(state), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("hs_fetch_go_strb", 32'(strobes), 32'b11100);
        tick();
        chk("hs_st_decode", 32'(state), 32'd1);
        tick();
        chk("hs_st_addr", 32'(state), 32'd4);
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) mem_ready = 1'b1;
            #1;
            chk($sformatf("hs_memwr_state%0d", k), 32'(state), 32'd6);
            chk($sformatf("hs_memwr_strb%0d", k), 32'(strobes), 32'b00010);
        end
        tick();
        chk("hs_st_done", 32'(state), 32'd0);
        // Reset during a MEM_WR wait
        tick();
        chk("hs2_decode", 32'(state), 32'd1);
        tick();
        chk("hs2_addr", 32'(state), 32'd4);
        mem_ready = 1'b0;
        tick();
        chk("hs2_memwr", 32'(state), 32'd6);
        rst = 1'b0;
        #1;
        chk("hs2_rst_strobes", 32'(strobes), 32'd0);
        tick();
        chk("hs2_rst_state", 32'(state), 32'd0);
        rst       = 1'b1;
        mem_ready = 1'b1;
`else
        // mem_ready held low: store still takes one cycle per memory state
        mem_ready = 1'b0;
        tick();
        chk("nohs_decode", 32'(state), 32'd1);
        tick();
        chk("nohs_addr", 32'(state), 32'd4);
        tick();
        chk("nohs_memwr", 32'(state), 32'd6);
        chk("nohs_memwr_ctrl", 32'(obs), 32'(E_MWR));
        tick();
        chk("nohs_fetch", 32'(state), 32'd0);
        chk("nohs_fetch_ctrl", 32'(obs), 32'(E_FETCH));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
